// File: rtl/hash_capture_buf.sv
// Captures one hash digest from the top-level byte stream, checks its length and
// offers the stored bytes for in-order, replayable readback.
module hash_capture_buf #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned HASH_BYTES = 32,
  parameter int unsigned CNT_W      = 9
) (
  input  logic              clk,
  input  logic              rst_async,
  input  logic              in_valid_i,
  input  logic              in_last_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              clear_i,
  input  logic              rd_req_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              done_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  byte_cnt_o,
  output logic [DATA_W-1:0] xor_o
);

  localparam int unsigned      AW        = (HASH_BYTES > 1) ? $clog2(HASH_BYTES) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(HASH_BYTES);
  localparam logic [AW-1:0]    LAST_ADDR = AW'(HASH_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_d;
  logic [CNT_W-1:0]    cnt_inc_c;
  logic [DATA_W-1:0]   xor_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                rd_valid_d;
  logic                done_d;
  logic                err_d;
  logic                wr_en_c;
  logic [AW-1:0]       wr_addr_c;
  logic                rd_en_c;
  logic                clr_data_c;

  logic [DATA_W-1:0]   mem [HASH_BYTES];

  assign cnt_inc_c = byte_cnt_o + CNT_W'(1);
  // The byte count doubles as the write address; it is 0 while idle.
  assign wr_addr_c = AW'(byte_cnt_o);

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = byte_cnt_o;
    xor_d      = xor_o;
    rd_ptr_d   = rd_ptr_q;
    rd_valid_d = 1'b0;
    done_d     = done_o;
    err_d      = err_o;
    wr_en_c    = 1'b0;
    rd_en_c    = 1'b0;
    clr_data_c = 1'b0;

    if (clear_i) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      xor_d      = '0;
      rd_ptr_d   = '0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      clr_data_c = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            wr_en_c = 1'b1;
            cnt_d   = CNT_W'(1);
            xor_d   = in_data_i;
            if (in_last_i) begin
              if (HASH_BYTES == 1) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = S_ERROR;
                err_d   = 1'b1;
              end
            end else begin
              state_d = S_CAPTURE;
            end
          end
        end

        S_CAPTURE: begin
          if (in_valid_i) begin
            if (byte_cnt_o == FULL_CNT) begin
              // Overflow: drop the byte and hold the saturated count.
              state_d = S_ERROR;
              err_d   = 1'b1;
            end else begin
              wr_en_c = 1'b1;
              cnt_d   = cnt_inc_c;
              xor_d   = xor_o ^ in_data_i;
              if (in_last_i) begin
                if (cnt_inc_c == FULL_CNT) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                end else begin
                  state_d = S_ERROR;
                  err_d   = 1'b1;
                end
              end
            end
          end
        end

        S_DONE: begin
          if (rd_req_i) begin
            rd_en_c    = 1'b1;
            rd_valid_d = 1'b1;
            rd_ptr_d   = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + AW'(1);
          end
        end

        S_ERROR: begin
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q    <= S_IDLE;
      byte_cnt_o <= '0;
      xor_o      <= '0;
      rd_ptr_q   <= '0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_o <= cnt_d;
      xor_o      <= xor_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_o <= rd_valid_d;
      done_o     <= done_d;
      err_o      <= err_d;
      if (clr_data_c) begin
        rd_data_o <= '0;
      end else if (rd_en_c) begin
        rd_data_o <= mem[rd_ptr_q];
      end
    end
  end

  // Digest storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_addr_c] <= in_data_i;
    end
  end

endmodule

// File: tb/tb_hash_capture_buf.sv
// Directed bench for hash_capture_buf: a queue-based digest model is compared
// against the DUT every cycle, with literal expectations pinning key points.
module tb_hash_capture_buf;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned HB     = 32;
  localparam int unsigned CNT_W  = 9;

  logic              clk = 1'b0;
  logic              rst_async;
  logic              in_valid;
  logic              in_last;
  logic [DATA_W-1:0] in_data;
  logic              clear;
  logic              rd_req;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  byte_cnt;
  logic [DATA_W-1:0] xor_sig;

  always #5 clk = ~clk;

  hash_capture_buf #(
    .DATA_W    (DATA_W),
    .HASH_BYTES(HB),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_async (rst_async),
    .in_valid_i(in_valid),
    .in_last_i (in_last),
    .in_data_i (in_data),
    .clear_i   (clear),
    .rd_req_i  (rd_req),
    .rd_valid_o(rd_valid),
    .rd_data_o (rd_data),
    .done_o    (done),
    .err_o     (err),
    .byte_cnt_o(byte_cnt),
    .xor_o     (xor_sig)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the accepted digest bytes plus completion/error flags and a read cursor.
  logic [7:0] m_q[$];
  bit         m_done, m_err, m_rdv;
  logic [7:0] m_x, m_rdd;
  int         m_rp;

  task automatic model_reset();
    m_q.delete();
    m_done = 1'b0;
    m_err  = 1'b0;
    m_rdv  = 1'b0;
    m_x    = 8'h00;
    m_rdd  = 8'h00;
    m_rp   = 0;
  endtask

  task automatic model_step();
    m_rdv = 1'b0;
    if (clear) begin
      model_reset();
    end else if (m_err) begin
    end else if (m_done) begin
      if (rd_req) begin
        m_rdd = m_q[m_rp];
        m_rdv = 1'b1;
        m_rp  = (m_rp + 1) % HB;
      end
    end else if (in_valid) begin
      if (m_q.size() == HB) begin
        m_err = 1'b1;
      end else begin
        m_q.push_back(in_data);
        m_x = m_x ^ in_data;
        if (in_last) begin
          if (m_q.size() == HB) m_done = 1'b1;
          else                  m_err  = 1'b1;
        end
      end
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m_rd_valid", 32'(rd_valid), 32'(m_rdv));
    chk("m_rd_data",  32'(rd_data),  32'(m_rdd));
    chk("m_done",     32'(done),     32'(m_done));
    chk("m_err",      32'(err),      32'(m_err));
    chk("m_byte_cnt", 32'(byte_cnt), 32'(m_q.size()));
    chk("m_xor",      32'(xor_sig),  32'(m_x));
  end

  task automatic cyc(input logic v, input logic l, input logic [7:0] d,
                     input logic c, input logic r);
    in_valid = v;
    in_last  = l;
    in_data  = d;
    clear    = c;
    rd_req   = r;
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic feed(input logic [7:0] d, input logic l);
    cyc(1'b1, l, d, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic rd();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic do_clear();
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    rst_async = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = 8'h00;
    clear     = 1'b0;
    rd_req    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    rst_async = 1'b0;
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err",  32'(err),  32'h0);
    chk("rst_cnt",  32'(byte_cnt), 32'h0);
    chk("rst_xor",  32'(xor_sig),  32'h0);
    idle();

    // Digest 0x00..0x1F; a read request while capturing is ignored.
    for (int i = 0; i < 31; i++) feed(8'(i), 1'b0);
    rd();
    chk("pre_last_done", 32'(done), 32'h0);
    chk("pre_last_cnt",  32'(byte_cnt), 32'd31);
    feed(8'h1F, 1'b1);
    chk("d1_done", 32'(done), 32'h1);
    chk("d1_cnt",  32'(byte_cnt), 32'd32);
    chk("d1_xor",  32'(xor_sig), 32'h00);
    for (int i = 0; i < 32; i++) begin
      rd();
      chk("d1_rd_valid", 32'(rd_valid), 32'h1);
      chk("d1_rd_data",  32'(rd_data),  32'(i));
    end
    rd();
    chk("d1_wrap", 32'(rd_data), 32'h00);
    idle();
    chk("d1_no_req_valid", 32'(rd_valid), 32'h0);

    // Extra byte in DONE is ignored; read cursor is at 1 after the wrap.
    feed(8'hFF, 1'b0);
    chk("done_ign_cnt", 32'(byte_cnt), 32'd32);
    chk("done_ign_xor", 32'(xor_sig),  32'h00);
    rd();
    chk("done_ign_rd", 32'(rd_data), 32'h01);

    do_clear();
    chk("clr_done", 32'(done), 32'h0);
    chk("clr_cnt",  32'(byte_cnt), 32'h0);
    chk("clr_rdd",  32'(rd_data), 32'h0);

    // Digest of 0x01 x32.
    for (int i = 0; i < 32; i++) feed(8'h01, i == 31);
    chk("d2_done", 32'(done), 32'h1);
    chk("d2_xor",  32'(xor_sig), 32'h00);
    for (int i = 0; i < 32; i++) begin
      rd();
      chk("d2_rd_data", 32'(rd_data), 32'h01);
    end

    // Short digest: 20 bytes of 0xA5.
    do_clear();
    for (int i = 0; i < 20; i++) feed(8'hA5, i == 19);
    chk("short_err",  32'(err),  32'h1);
    chk("short_done", 32'(done), 32'h0);
    chk("short_cnt",  32'(byte_cnt), 32'd20);
    chk("short_xor",  32'(xor_sig),  32'h00);
    rd();
    chk("short_rd_valid", 32'(rd_valid), 32'h0);
    feed(8'h33, 1'b1);
    chk("short_frozen_cnt", 32'(byte_cnt), 32'd20);

    // Overflow: bytes 0..30, 0x5A, then 0xEE with no last.
    do_clear();
    for (int i = 0; i < 31; i++) feed(8'(i), 1'b0);
    feed(8'h5A, 1'b0);
    chk("ovf_32_err", 32'(err), 32'h0);
    feed(8'hEE, 1'b0);
    chk("ovf_err", 32'(err), 32'h1);
    chk("ovf_cnt", 32'(byte_cnt), 32'd32);
    chk("ovf_xor", 32'(xor_sig), 32'h45);

    // Reset mid-capture, then a full digest 0xC0..0xDF.
    do_clear();
    for (int i = 0; i < 10; i++) feed(8'h80 + 8'(i), 1'b0);
    in_valid  = 1'b0;
    rst_async = 1'b1;
    model_reset();
    #1;
    chk("arst_cnt", 32'(byte_cnt), 32'h0);
    chk("arst_xor", 32'(xor_sig), 32'h0);
    @(posedge clk);
    #2;
    rst_async = 1'b0;
    for (int i = 0; i < 32; i++) feed(8'hC0 + 8'(i), i == 31);
    chk("d3_done", 32'(done), 32'h1);
    chk("d3_cnt",  32'(byte_cnt), 32'd32);
    chk("d3_xor",  32'(xor_sig), 32'h00);
    for (int i = 0; i < 32; i++) begin
      rd();
      chk("d3_rd_data", 32'(rd_data), 32'hC0 + 32'(i));
    end

    // Clear with a coincident byte drops that byte.
    cyc(1'b1, 1'b0, 8'h99, 1'b1, 1'b0);
    chk("clr_drop_cnt", 32'(byte_cnt), 32'h0);
    chk("clr_drop_xor", 32'(xor_sig), 32'h0);
    feed(8'h77, 1'b0);
    chk("after_clr_cnt", 32'(byte_cnt), 32'd1);
    chk("after_clr_xor", 32'(xor_sig), 32'h77);
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
